// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: op/state encodings,
// store strobe generation and the access fault check.
package lsu_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_LANES      = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    RESP
  } lsu_state_e;

  function automatic logic [NUM_LANES-1:0] wstrb_for(logic [2:0] op, logic [1:0] addr_lo);
    logic [NUM_LANES-1:0] s;
    case (op)
      MEM_B:   s = 4'b0001 << addr_lo;
      MEM_H:   s = 4'b0011 << {addr_lo[1], 1'b0};
      MEM_W:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // True for any request that cannot be issued as one aligned transfer:
  // bad alignment, reserved op codes, or unsigned widths on a store.
  function automatic logic is_misaligned(logic [2:0] op, logic [1:0] addr_lo, logic store);
    logic f;
    case (op)
      MEM_B:         f = 1'b0;
      MEM_BU:        f = store;
      MEM_H:         f = addr_lo[0];
      MEM_HU:        f = store | addr_lo[0];
      MEM_W:         f = |addr_lo;
      default:       f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, data-memory and response channels of the load/store unit.
interface lsu_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_store;
  logic [2:0]                req_op;
  logic [DATA_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [REG_ADDR_WIDTH-1:0] req_rd;

  logic                      mem_valid;
  logic                      mem_ready;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_wstrb;
  logic                      mem_rvalid;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_WIDTH-1:0]     resp_data;
  logic [REG_ADDR_WIDTH-1:0] resp_rd;
  logic                      resp_fault;

  // LSU side
  modport slave (
    input  req_valid, req_store, req_op, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata,
    output resp_valid, resp_data, resp_rd, resp_fault,
    input  resp_ready
  );

  // Pipeline / memory / writeback side
  modport master (
    output req_valid, req_store, req_op, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata,
    input  resp_valid, resp_data, resp_rd, resp_fault,
    output resp_ready
  );
endinterface

// File: rtl/lsu_align.sv
// Load return path: moves the addressed byte/half to bit 0 and extends it.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [2:0]            op_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [DATA_WIDTH-1:0] sh;

  assign sh = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = sh;
    case (op_i)
      MEM_B:   data_o = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      MEM_BU:  data_o = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      MEM_H:   data_o = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      MEM_HU:  data_o = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      default: data_o = sh;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding memory-access stage: address/op capture, fault check,
// one data-memory transaction, extended load value back to writeback.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);
  localparam int NL = DATA_WIDTH / 8;

  lsu_state_e                state_q, state_d;
  logic                      store_q, store_d;
  logic [2:0]                op_q, op_d;
  logic [DATA_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      fault_q, fault_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

  logic                      accept;
  logic                      in_req;
  logic [DATA_WIDTH-1:0]     ld_val;
  logic [NL-1:0][7:0]        lane_w;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .rdata_i   (bus.mem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .op_i      (op_q),
    .data_o    (ld_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        store_d = bus.req_store;
        op_d    = bus.req_op;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        rd_d    = bus.req_rd;
        fault_d = is_misaligned(bus.req_op, bus.req_addr[1:0], bus.req_store);
        rdata_d = '0;
        state_d = fault_d ? RESP : REQ;
      end
      REQ: if (bus.mem_ready) state_d = store_q ? RESP : WAIT_R;
      WAIT_R: if (bus.mem_rvalid) begin
        rdata_d = ld_val;
        state_d = RESP;
      end
      RESP: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte lanes of the store word; only B/H/W reach REQ as stores.
  for (genvar i = 0; i < NL; i++) begin : g_lane
    assign lane_w[i] = (op_q == MEM_B) ? wdata_q[7:0] :
                       (op_q == MEM_H) ? wdata_q[8*(i%2) +: 8] :
                                         wdata_q[8*i +: 8];
  end

  assign in_req        = (state_q == REQ);
  assign bus.req_ready = rst_n && (state_q == IDLE);

  assign bus.mem_valid = in_req;
  assign bus.mem_we    = in_req && store_q;
  assign bus.mem_addr  = in_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_wdata = (in_req && store_q) ? lane_w : '0;
  assign bus.mem_wstrb = (in_req && store_q) ? wstrb_for(op_q, addr_q[1:0]) : '0;

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = rdata_q;
  assign bus.resp_rd    = rd_q;
  assign bus.resp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: latency, lane steering, extension,
// faults, stalls and mid-transaction reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  load_store_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        saw_mem;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mstrb;
    logic        mwe;
    int          resp_cyc;
    logic [31:0] rdata;
    logic        fault;
    logic [4:0]  rd;
    int          nresp;
    logic        stable_ok;
    logic        rr_low_ok;
    logic        ready_after;
  } obs_t;

  // Drives one request and plays memory/writeback with the given stall counts.
  task automatic run_txn(input logic st, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdat,
                         input int rdy_dly, input int rv_dly, input int rsp_dly, output obs_t o);
    int c, mv_n, rv_n, rs_n;
    logic arm, rpend, done;
    c = 0; mv_n = 0; rv_n = 0; rs_n = 0; arm = 0; rpend = 0; done = 0;
    o = '{default: 0};
    o.resp_cyc = -1; o.stable_ok = 1; o.rr_low_ok = 1;
    bus.req_valid = 1; bus.req_store = st; bus.req_op = op;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_rd = rd;
    @(posedge clk); #1;
    bus.req_valid = 0; c = 1;
    while (!done && c < 80) begin
      bus.mem_ready = 0; bus.mem_rvalid = 0; bus.resp_ready = 0;
      if (bus.req_ready) o.rr_low_ok = 0;
      if (rpend) begin
        if (rv_n >= rv_dly) begin bus.mem_rvalid = 1; bus.mem_rdata = rdat; rpend = 0; end
        rv_n++;
      end
      if (bus.mem_valid) begin
        if (!o.saw_mem) begin
          o.saw_mem = 1; o.maddr = bus.mem_addr; o.mwdata = bus.mem_wdata;
          o.mstrb = bus.mem_wstrb; o.mwe = bus.mem_we;
        end else if ({o.maddr, o.mwdata, o.mstrb, o.mwe} !==
                     {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_we})
          o.stable_ok = 0;
        if (mv_n >= rdy_dly) begin
          bus.mem_ready = 1;
          if (!bus.mem_we) arm = 1;
        end else begin
          bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0BAD0;
        end
        mv_n++;
      end
      if (bus.resp_valid) begin
        if (o.resp_cyc < 0) begin
          o.resp_cyc = c; o.rdata = bus.resp_data; o.fault = bus.resp_fault; o.rd = bus.resp_rd;
        end else if ({o.rdata, o.fault, o.rd} !== {bus.resp_data, bus.resp_fault, bus.resp_rd})
          o.stable_ok = 0;
        if (rs_n >= rsp_dly) begin bus.resp_ready = 1; done = 1; end
        rs_n++;
      end
      @(posedge clk); #1; c++;
      if (arm) begin rpend = 1; arm = 0; end
    end
    o.nresp = (o.resp_cyc >= 0) ? 1 : 0;
    o.ready_after = bus.req_ready;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.resp_ready = 0;
    repeat (3) begin
      if (bus.resp_valid) o.nresp++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] outs_hi;
    bus.req_valid = 0; bus.req_store = 0; bus.req_op = 0; bus.req_addr = 0;
    bus.req_wdata = 0; bus.req_rd = 0; bus.mem_ready = 0; bus.mem_rvalid = 0;
    bus.mem_rdata = 0; bus.resp_ready = 0;
    rst_n = 0;
    #23;
    checks++;
    if ({bus.req_ready, bus.mem_valid, bus.mem_we, bus.resp_valid, bus.resp_fault,
         bus.mem_wstrb, bus.resp_rd} !== 13'd0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0", {bus.req_ready, bus.mem_valid, bus.mem_we,
               bus.resp_valid, bus.resp_fault, bus.mem_wstrb, bus.resp_rd});
    end
    outs_hi = bus.mem_addr | bus.mem_wdata | bus.resp_data;
    checks++;
    if (outs_hi !== 32'd0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", outs_hi);
    end
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready);
    end
  endtask

  task automatic test_load_word();
    obs_t o;
    run_txn(0, MEM_W, 32'h100, 32'hFFFF_FFFF, 5'd7, 32'hDEADBEEF, 0, 0, 0, o);
    checks++;
    if (o.maddr !== 32'h100 || o.mstrb !== 4'b0000 || o.mwe !== 1'b0 || o.mwdata !== 0) begin
      errors++; $display("FAIL lw_mem got addr=%h strb=%b we=%b wd=%h exp 100/0000/0/0",
                         o.maddr, o.mstrb, o.mwe, o.mwdata);
    end
    checks++;
    if (o.resp_cyc !== 3) begin errors++; $display("FAIL lw_latency got=%0d exp=3", o.resp_cyc); end
    checks++;
    if (o.rdata !== 32'hDEADBEEF || o.fault !== 1'b0 || o.rd !== 5'd7) begin
      errors++; $display("FAIL lw_resp got data=%h fault=%b rd=%0d exp deadbeef/0/7",
                         o.rdata, o.fault, o.rd);
    end
    checks++;
    if (o.nresp !== 1 || o.ready_after !== 1'b1) begin
      errors++; $display("FAIL lw_done got nresp=%0d ready=%b exp 1/1", o.nresp, o.ready_after);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  ops [9] = '{MEM_B, MEM_BU, MEM_H, MEM_HU, MEM_B, MEM_B, MEM_B, MEM_HU, MEM_H};
    logic [31:0] adr [9] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h102,
                             32'h100, 32'h100};
    logic [31:0] exp [9] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                             32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'h00007F01,
                             32'h00007F01};
    obs_t o;
    for (int i = 0; i < 9; i++) begin
      run_txn(0, ops[i], adr[i], 32'h0, 5'(i + 1), 32'h80FF7F01, 0, 0, 0, o);
      checks++;
      if (o.rdata !== exp[i] || o.fault !== 1'b0 || o.resp_cyc !== 3 || o.maddr !== 32'h100) begin
        errors++; $display("FAIL ld_ext[%0d] got data=%h fault=%b cyc=%0d addr=%h exp %h/0/3/100",
                           i, o.rdata, o.fault, o.resp_cyc, o.maddr, exp[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [2:0]  ops [5] = '{MEM_B, MEM_H, MEM_W, MEM_B, MEM_H};
    logic [31:0] adr [5] = '{32'h201, 32'h202, 32'h30C, 32'h200, 32'h200};
    logic [31:0] wd  [5] = '{32'h12345678, 32'h12345678, 32'hA5A51234, 32'hCAFE00AB, 32'h9999BEEF};
    logic [31:0] ea  [5] = '{32'h200, 32'h200, 32'h30C, 32'h200, 32'h200};
    logic [31:0] ewd [5] = '{32'h78787878, 32'h56785678, 32'hA5A51234, 32'hABABABAB, 32'hBEEFBEEF};
    logic [3:0]  est [5] = '{4'b0010, 4'b1100, 4'b1111, 4'b0001, 4'b0011};
    obs_t o;
    for (int i = 0; i < 5; i++) begin
      run_txn(1, ops[i], adr[i], wd[i], 5'(20 + i), 32'h0, 0, 0, 0, o);
      checks++;
      if (o.maddr !== ea[i] || o.mwdata !== ewd[i] || o.mstrb !== est[i] || o.mwe !== 1'b1) begin
        errors++; $display("FAIL st_lane[%0d] got a=%h wd=%h s=%b we=%b exp %h/%h/%b/1",
                           i, o.maddr, o.mwdata, o.mstrb, o.mwe, ea[i], ewd[i], est[i]);
      end
      checks++;
      if (o.resp_cyc !== 2 || o.rdata !== 0 || o.fault !== 1'b0 || o.rd !== 5'(20 + i)) begin
        errors++; $display("FAIL st_resp[%0d] got cyc=%0d data=%h fault=%b rd=%0d exp 2/0/0/%0d",
                           i, o.resp_cyc, o.rdata, o.fault, o.rd, 20 + i);
      end
    end
  endtask

  task automatic test_fault();
    logic        sts [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  ops [6] = '{MEM_W, MEM_H, 3'b011, MEM_BU, 3'b111, MEM_HU};
    logic [31:0] adr [6] = '{32'h101, 32'h103, 32'h100, 32'h100, 32'h100, 32'h105};
    obs_t o;
    for (int i = 0; i < 6; i++) begin
      // preceding load leaves a nonzero value in the response register
      run_txn(0, MEM_W, 32'h100, 32'h0, 5'd1, 32'h5555AAAA, 0, 0, 0, o);
      run_txn(sts[i], ops[i], adr[i], 32'hFFFFFFFF, 5'(10 + i), 32'h0, 0, 0, 0, o);
      checks++;
      if (o.saw_mem !== 1'b0 || o.resp_cyc !== 1 || o.fault !== 1'b1 || o.rdata !== 0 ||
          o.rd !== 5'(10 + i) || o.nresp !== 1) begin
        errors++; $display("FAIL fault[%0d] got mem=%b cyc=%0d fault=%b data=%h rd=%0d n=%0d exp 0/1/1/0/%0d/1",
                           i, o.saw_mem, o.resp_cyc, o.fault, o.rdata, o.rd, o.nresp, 10 + i);
      end
    end
  endtask

  task automatic test_stall();
    obs_t o;
    run_txn(0, MEM_W, 32'h104, 32'h0, 5'd9, 32'hCAFEF00D, 3, 5, 2, o);
    checks++;
    if (o.stable_ok !== 1'b1 || o.rr_low_ok !== 1'b1 || o.nresp !== 1) begin
      errors++; $display("FAIL stall_ld_hold got stable=%b rrlow=%b n=%0d exp 1/1/1",
                         o.stable_ok, o.rr_low_ok, o.nresp);
    end
    checks++;
    if (o.rdata !== 32'hCAFEF00D || o.resp_cyc !== 11 || o.maddr !== 32'h104) begin
      errors++; $display("FAIL stall_ld_resp got data=%h cyc=%0d addr=%h exp cafef00d/11/104",
                         o.rdata, o.resp_cyc, o.maddr);
    end
    run_txn(1, MEM_H, 32'h202, 32'h0000_1234, 5'd3, 32'h0, 3, 0, 2, o);
    checks++;
    if (o.stable_ok !== 1'b1 || o.rr_low_ok !== 1'b1 || o.nresp !== 1 || o.resp_cyc !== 5 ||
        o.mwdata !== 32'h12341234 || o.mstrb !== 4'b1100) begin
      errors++; $display("FAIL stall_st got stable=%b rrlow=%b n=%0d cyc=%0d wd=%h s=%b exp 1/1/1/5/12341234/1100",
                         o.stable_ok, o.rr_low_ok, o.nresp, o.resp_cyc, o.mwdata, o.mstrb);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic seen;
    bus.req_valid = 1; bus.req_store = 0; bus.req_op = MEM_W; bus.req_addr = 32'h100;
    bus.req_rd = 5'd4;
    @(posedge clk); #1;
    bus.req_valid = 0; bus.mem_ready = 1;
    @(posedge clk); #1;
    bus.mem_ready = 0;
    checks++;
    if (bus.mem_valid !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_wait got mv=%b rv=%b rr=%b exp 0/0/0",
                         bus.mem_valid, bus.resp_valid, bus.req_ready);
    end
    #2; rst_n = 0; #1;
    checks++;
    if ({bus.req_ready, bus.mem_valid, bus.resp_valid, bus.resp_fault, bus.mem_wstrb,
         bus.resp_rd, bus.mem_addr, bus.resp_data} !== 73'd0) begin
      errors++; $display("FAIL rst_mid_outs got rr=%b mv=%b rv=%b addr=%h data=%h rd=%0d exp all 0",
                         bus.req_ready, bus.mem_valid, bus.resp_valid, bus.mem_addr,
                         bus.resp_data, bus.resp_rd);
    end
    #3; rst_n = 1;
    @(posedge clk); #1;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h11111111;
    @(posedge clk); #1;
    bus.mem_rvalid = 0;
    seen = 0;
    repeat (4) begin
      if (bus.resp_valid) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_late_rvalid got resp_seen=%b ready=%b exp 0/1", seen, bus.req_ready);
    end
    run_txn(0, MEM_W, 32'h108, 32'h0, 5'd6, 32'h0BADF00D, 0, 0, 0, o);
    checks++;
    if (o.rdata !== 32'h0BADF00D || o.resp_cyc !== 3 || o.fault !== 1'b0 || o.rd !== 5'd6) begin
      errors++; $display("FAIL rst_recover got data=%h cyc=%0d fault=%b rd=%0d exp 0badf00d/3/0/6",
                         o.rdata, o.resp_cyc, o.fault, o.rd);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    run_txn(1, MEM_W, 32'h400, 32'h01020304, 5'd2, 32'h0, 0, 0, 0, o);
    checks++;
    if (o.ready_after !== 1'b1 || o.resp_cyc !== 2) begin
      errors++; $display("FAIL b2b_first got ready=%b cyc=%0d exp 1/2", o.ready_after, o.resp_cyc);
    end
    run_txn(0, MEM_HU, 32'h402, 32'h0, 5'd3, 32'h01020304, 0, 0, 0, o);
    checks++;
    if (o.rdata !== 32'h00000102 || o.resp_cyc !== 3) begin
      errors++; $display("FAIL b2b_second got data=%h cyc=%0d exp 00000102/3", o.rdata, o.resp_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_fault();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU. Takes the ALU result as an effective address, plus store data and a load/store op. Runs one data-memory transaction over a valid/ready request channel and an rvalid read-return channel. Returns the aligned, sign/zero-extended load value, or a fault, to writeback through a valid/ready response channel.

Parameters:
DATA_WIDTH, 32, data and address width; only 32 is supported, so strobe width is DATA_WIDTH/8 = 4.
REG_ADDR_WIDTH, 5, destination-register tag width.

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  upstream request valid
req_ready  output  1  LSU can accept a request
req_store  input  1  1 = store, 0 = load
req_op  input  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  DATA_WIDTH  effective address (ALU result)
req_wdata  input  DATA_WIDTH  store data; value in low bits
req_rd  input  REG_ADDR_WIDTH  destination tag, passed through
mem_valid  output  1  memory request valid
mem_ready  input  1  memory accepts request
mem_we  output  1  write enable
mem_addr  output  DATA_WIDTH  word address; bits [1:0] forced to 0
mem_wdata  output  DATA_WIDTH  lane-replicated store data
mem_wstrb  output  4  byte-lane write strobes
mem_rvalid  input  1  read data valid
mem_rdata  input  DATA_WIDTH  read word
resp_valid  output  1  response valid
resp_ready  input  1  writeback accepts response
resp_data  output  DATA_WIDTH  extended load value; 0 for stores and faults
resp_rd  output  REG_ADDR_WIDTH  captured req_rd
resp_fault  output  1  misaligned access or illegal op

Behaviour:
- Reset: state IDLE. Every output is 0 while rst_n is low, including req_ready (req_ready = rst_n && state==IDLE). All captured registers clear to 0.
- FSM states: IDLE, REQ, WAIT_R, RESP. Only one transaction is in flight; there is no pipelining.
- IDLE:
  - A transfer occurs on req_valid && req_ready. The LSU latches store, op, addr, wdata and rd.
  - Fault check: fault if op is 011, 110 or 111; if store with op 100 or 101; if halfword with addr[0]!=0; or if word with addr[1:0]!=0.
  - On fault, go to RESP with resp_fault=1 and resp_data=0. No memory access is made.
  - Otherwise go to REQ.
- REQ:
  - mem_valid=1. mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_ready.
  - When mem_ready: a store goes to RESP; a load goes to WAIT_R.
  - mem_rvalid seen while in REQ is ignored.
- Store lanes:
  - B: mem_wdata = 4 copies of wdata[7:0]; strobe = 0001 << addr[1:0].
  - H: mem_wdata = 2 copies of wdata[15:0]; strobe = 0011 << (2*addr[1]).
  - W: mem_wdata = wdata; strobe = 1111.
  - For loads, strobe = 0000 and mem_wdata = 0.
- WAIT_R: on mem_rvalid, shift mem_rdata right by 8*addr[1:0], then extend:
  - B: sign-extend bit 7.
  - BU: zero-extend from 8 bits.
  - H: sign-extend bit 15.
  - HU: zero-extend from 16 bits.
  - W: unchanged.
  - Register the result into resp_data and go to RESP. Wait time is unbounded.
- RESP:
  - resp_valid=1. resp_data, resp_rd and resp_fault are held stable until resp_ready.
  - When resp_ready, go to IDLE. req_ready returns the following cycle; there is no same-cycle bypass.
- Latency with zero-wait memory and resp_ready=1. Request accepted in cycle 0:
  - Load: mem_valid in cycle 1, rvalid in cycle 2, resp_valid in cycle 3.
  - Store: resp_valid in cycle 2.
  - Fault: resp_valid in cycle 1.
- Async reset mid-transaction abandons it: mem_valid and resp_valid drop immediately. A late mem_rvalid that arrives in IDLE is ignored.
- An address wrap-around at 0xFFFF_FFFC is not special-cased.

Decomposition:
- Package lsu_pkg holds:
  - the mem_op_e enum (MEM_B=3'b000, MEM_H, MEM_W, MEM_BU=3'b100, MEM_HU);
  - the lsu_state_e enum (IDLE, REQ, WAIT_R, RESP);
  - function wstrb_for(op, addr_lo);
  - function is_misaligned(op, addr_lo, store).
- Sub-module lsu_align is purely combinational. It takes rdata, addr_lo and op, and produces the extended load value. It is instantiated once, feeding the WAIT_R capture.

Test Plan:
- LW at addr 0x100, memory returns 0xDEADBEEF with zero wait -> mem_addr=0x100, wstrb=0000; resp_data=0xDEADBEEF and resp_fault=0 at cycle 3.
- LB at 0x103, LBU at 0x103, LH at 0x102 and LHU at 0x102, rdata 0x80FF7F01 -> resp_data 0xFFFFFF80, 0x00000080, 0xFFFF80FF and 0x000080FF respectively.
- SB at 0x201, wdata 0x12345678 -> mem_addr=0x200, mem_wdata=0x78787878, wstrb=0010, mem_we=1; SH at 0x202 -> wdata=0x56785678, wstrb=1100.
- LW at 0x101 and SH at 0x103 -> no mem_valid ever asserts; resp_fault=1 and resp_data=0 at cycle 1. Op 011 also faults.
- mem_ready held low 3 cycles, mem_rvalid delayed 5 cycles, resp_ready low 2 cycles -> all mem_* and resp_* outputs stay stable while stalled; exactly one response; req_ready low throughout.
- rst_n pulsed low while in WAIT_R -> all outputs 0 immediately; after release, a late mem_rvalid produces no response; the next LW completes normally.
